lut4_cfg: RTL and testbench

- Programmable 4-input look-up table (LUT4) cell, the basic logic element of the fabric.
- Output O is the INIT bit selected by the 4-bit input I.
- A 16-bit configuration register holds INIT. It is clocked by clk, loadable in parallel or through a serial scan chain, and restored to a default on reset.
- The default INIT implements O = ~(I[2] & I[0]).

---
 rtl/lut_pkg.sv | 10 +
 rtl/lut4_cfg_if.sv | 22 ++
 rtl/lut4_cfg_reg.sv | 28 ++
 rtl/lut4_cfg.sv | 48 ++++
 tb/tb_lut4_cfg.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lut_pkg.sv
// Shared constants and types for the LUT4 fabric cell.
// Default INIT 16'h5F5F realises O = ~(I[2] & I[0]).
package lut_pkg;
  localparam int LUT_K    = 4;
  localparam int LUT_SIZE = 16;

  typedef logic [LUT_SIZE-1:0] lut_init_t;

  localparam lut_init_t NAND_I2_I0_INIT = 16'h5F5F;
endpackage

// File: rtl/lut4_cfg_if.sv
// Configuration port of a LUT4 cell: parallel load,
// scan chain and INIT readback.
interface lut4_cfg_if;
  import lut_pkg::*;

  logic      cfg_we;
  lut_init_t cfg_data;
  logic      cfg_shift_en;
  logic      cfg_sin;
  logic      cfg_sout;
  lut_init_t init_q;

  modport master (
    output cfg_we, cfg_data, cfg_shift_en, cfg_sin,
    input  cfg_sout, init_q
  );

  modport slave (
    input  cfg_we, cfg_data, cfg_shift_en, cfg_sin,
    output cfg_sout, init_q
  );
endinterface

// File: rtl/lut4_cfg_reg.sv
// INIT register with parallel load, serial scan
// and asynchronous restore to the default table.
module lut4_cfg_reg
  import lut_pkg::*;
#(
  parameter lut_init_t INIT_DEFAULT = NAND_I2_I0_INIT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      cfg_we,
  input  lut_init_t cfg_data,
  input  logic      cfg_shift_en,
  input  logic      cfg_sin,
  output lut_init_t init_q
);

  // Parallel write has priority over shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= INIT_DEFAULT;
    end else if (cfg_we) begin
      init_q <= cfg_data;
    end else if (cfg_shift_en) begin
      init_q <= {init_q[LUT_SIZE-2:0], cfg_sin};
    end
  end

endmodule

// File: rtl/lut4_cfg.sv
// Programmable LUT4 cell: 16:1 table mux over the
// INIT register, with an optional registered output.
module lut4_cfg
  import lut_pkg::*;
#(
  parameter lut_init_t INIT_DEFAULT = NAND_I2_I0_INIT,
  parameter bit        OUT_REG      = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LUT_K-1:0] I,
  output logic             O,
  output logic             O_q,
  lut4_cfg_if.slave        cfg
);

  lut_init_t init_q;

  lut4_cfg_reg #(
    .INIT_DEFAULT (INIT_DEFAULT)
  ) u_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg.cfg_we),
    .cfg_data     (cfg.cfg_data),
    .cfg_shift_en (cfg.cfg_shift_en),
    .cfg_sin      (cfg.cfg_sin),
    .init_q       (init_q)
  );

  assign cfg.init_q   = init_q;
  assign cfg.cfg_sout = init_q[LUT_SIZE-1];

  assign O = init_q[I];

  if (OUT_REG) begin : g_oreg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        O_q <= 1'b0;
      end else begin
        O_q <= O;
      end
    end
  end else begin : g_nooreg
    assign O_q = 1'b0;
  end

endmodule

// File: tb/tb_lut4_cfg.sv
// Self-checking bench for lut4_cfg (OUT_REG=1) against
// a truth-table model of the configured cell.
module tb_lut4_cfg;
  import lut_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] I = 4'd0;
  logic       O;
  logic       O_q;

  int passed = 0;
  int total  = 0;

  logic [15:0] model;
  logic        oq_model;

  lut4_cfg_if cfg ();

  lut4_cfg #(
    .INIT_DEFAULT (16'h5F5F),
    .OUT_REG      (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .I     (I),
    .O     (O),
    .O_q   (O_q),
    .cfg   (cfg.master)
  );

  always #5 clk = ~clk;

  function automatic logic nand_ref(input logic [3:0] v);
    return !(v[2] && v[0]);
  endfunction

  task automatic idle();
    cfg.cfg_we       = 1'b0;
    cfg.cfg_shift_en = 1'b0;
    cfg.cfg_sin      = 1'b0;
    cfg.cfg_data     = 16'h0;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    total++;
    if (cfg.init_q !== 16'h5F5F)
      $display("FAIL reset_init got %h want 5f5f", cfg.init_q);
    else passed++;
    total++;
    if (O_q !== 1'b0)
      $display("FAIL reset_oq got %b want 0", O_q);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model = 16'h5F5F;
    edge_step();
  endtask

  task automatic test_default();
    logic [3:0] pat [8];
    pat = '{4'b0000, 4'b1001, 4'b1010, 4'b1011,
            4'b0101, 4'b0001, 4'b0100, 4'b0111};
    foreach (pat[k]) begin
      I = pat[k];
      #25;
      total++;
      if (O !== nand_ref(pat[k]))
        $display("FAIL default_o I=%b got %b want %b",
                 pat[k], O, nand_ref(pat[k]));
      else passed++;
    end
  endtask

  task automatic sweep(input string nm);
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      I = 4'(i);
      #1;
      if (O !== model[i]) bad++;
    end
    total++;
    if (bad != 0)
      $display("FAIL %s got %0d bad entries want 0", nm, bad);
    else passed++;
  endtask

  task automatic test_parallel();
    idle();
    cfg.cfg_we   = 1'b1;
    cfg.cfg_data = 16'h8000;
    edge_step();
    idle();
    model = 16'h8000;
    total++;
    if (cfg.init_q !== 16'h8000)
      $display("FAIL par_8000 got %h want 8000", cfg.init_q);
    else passed++;
    sweep("par_8000_sweep");
    cfg.cfg_we   = 1'b1;
    cfg.cfg_data = 16'h0001;
    edge_step();
    idle();
    model = 16'h0001;
    sweep("par_0001_sweep");
  endtask

  task automatic test_serial();
    logic [15:0] v = 16'hA5C3;
    int sout_bad = 0;
    idle();
    for (int k = 15; k >= 0; k--) begin
      if (cfg.cfg_sout !== model[15]) sout_bad++;
      cfg.cfg_shift_en = 1'b1;
      cfg.cfg_sin      = v[k];
      edge_step();
      model = {model[14:0], v[k]};
    end
    idle();
    total++;
    if (sout_bad != 0 || cfg.cfg_sout !== model[15])
      $display("FAIL ser_sout got %0d bad want 0", sout_bad);
    else passed++;
    total++;
    if (cfg.init_q !== 16'hA5C3)
      $display("FAIL ser_init got %h want a5c3", cfg.init_q);
    else passed++;
    sweep("ser_sweep");
  endtask

  task automatic test_collision();
    cfg.cfg_we       = 1'b1;
    cfg.cfg_shift_en = 1'b1;
    cfg.cfg_sin      = 1'b1;
    cfg.cfg_data     = 16'h1234;
    edge_step();
    idle();
    model = 16'h1234;
    total++;
    if (cfg.init_q !== 16'h1234)
      $display("FAIL collide got %h want 1234", cfg.init_q);
    else passed++;
    edge_step();
    total++;
    if (cfg.init_q !== 16'h1234)
      $display("FAIL hold got %h want 1234", cfg.init_q);
    else passed++;
  endtask

  task automatic test_reset_mid_shift();
    I = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      cfg.cfg_shift_en = 1'b1;
      cfg.cfg_sin      = k[0];
      edge_step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    idle();
    model = 16'h5F5F;
    total++;
    if (cfg.init_q !== 16'h5F5F)
      $display("FAIL midrst_init got %h want 5f5f", cfg.init_q);
    else passed++;
    total++;
    if (O_q !== 1'b0 || O !== 1'b0)
      $display("FAIL midrst_o got O=%b O_q=%b want 0 0", O, O_q);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    edge_step();
  endtask

  task automatic test_oreg();
    I = 4'b0000;
    edge_step();
    total++;
    if (O_q !== 1'b1)
      $display("FAIL oq_high got %b want 1", O_q);
    else passed++;
    I = 4'b0101;
    #1;
    total++;
    if (O !== 1'b0 || O_q !== 1'b1)
      $display("FAIL oq_lag got O=%b O_q=%b want 0 1", O, O_q);
    else passed++;
    edge_step();
    total++;
    if (O_q !== 1'b0)
      $display("FAIL oq_fall got %b want 0", O_q);
    else passed++;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 200; n++) begin
      cfg.cfg_we       = ($urandom_range(0, 4) == 0);
      cfg.cfg_shift_en = ($urandom_range(0, 1) == 1);
      cfg.cfg_sin      = 1'($urandom);
      cfg.cfg_data     = 16'($urandom);
      I                = 4'($urandom);
      #1;
      if (O !== model[I]) bad++;
      oq_model = model[I];
      if (cfg.cfg_we) model = cfg.cfg_data;
      else if (cfg.cfg_shift_en)
        model = {model[14:0], cfg.cfg_sin};
      edge_step();
      if (cfg.init_q !== model || O_q !== oq_model
          || cfg.cfg_sout !== model[15]) bad++;
    end
    idle();
    total++;
    if (bad != 0)
      $display("FAIL random got %0d bad cycles want 0", bad);
    else passed++;
  endtask

  initial begin
    model    = 16'h5F5F;
    oq_model = 1'b0;
    test_reset();
    test_default();
    test_parallel();
    test_serial();
    test_collision();
    test_reset_mid_shift();
    test_oreg();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
